// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: merges the instruction-fetch master (m0)
// and the MEM-stage data master (m1) onto one slave port. Ownership is
// round-robin on ties and locked for the whole cycle (held until the owner
// drops cyc). Data and ack paths between owner and slave are combinational.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,

  output logic [1:0]              grant_o
);

  // Encoding chosen so the state register itself is the one-hot grant
  // vector; grant_o then comes straight off flops and cannot glitch.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_M0 = 2'b01,
    OWN_M1 = 2'b10
  } arb_state_e;

  arb_state_e state;
  arb_state_e next_state;
  logic       last;
  logic       next_last;

  // State register plus the "last granted master" bit, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // Next-state logic: tie goes to the master that did not own the bus last;
  // an owner keeps the bus until its cyc drops, then the waiting master wins
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          next_state = last ? OWN_M0 : OWN_M1;
        end else if (m0_wb_cyc_i) begin
          next_state = OWN_M0;
        end else if (m1_wb_cyc_i) begin
          next_state = OWN_M1;
        end
      end
      OWN_M0: begin
        if (!m0_wb_cyc_i) begin
          next_state = m1_wb_cyc_i ? OWN_M1 : IDLE;
        end
      end
      OWN_M1: begin
        if (!m1_wb_cyc_i) begin
          next_state = m0_wb_cyc_i ? OWN_M0 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    next_last = last;
    if (next_state != state) begin
      if (next_state == OWN_M0) begin
        next_last = 1'b0;
      end else if (next_state == OWN_M1) begin
        next_last = 1'b1;
      end
    end
  end

  // Output mux: owner's request passes through to the slave, slave ack goes
  // only to the current owner so a late ack after abandonment is dropped
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    case (state)
      OWN_M0: begin
        s_wb_cyc_o  = m0_wb_cyc_i;
        s_wb_stb_o  = m0_wb_stb_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_sel_o  = m0_wb_sel_i;
        m0_wb_ack_o = s_wb_ack_i;
      end
      OWN_M1: begin
        s_wb_cyc_o  = m1_wb_cyc_i;
        s_wb_stb_o  = m1_wb_stb_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_sel_o  = m1_wb_sel_i;
        m1_wb_ack_o = s_wb_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign grant_o     = state;

endmodule
